phase_cache_pp: RTL and testbench
=================================

Name: phase_cache_pp

Overview:
- Double-buffered (ping-pong) successor of the single-row phase cache in the phase-match pipeline.
- Accepts one row of phase samples per AXI-stream packet and packs them into WIN_SIZE-sample window words.
- Stores each row in one of two banks, and serves NUM_RD independent window-read ports from the completed bank while the next row loads.
- Adds backpressure, explicit bank hand-off, row-length checking and a configurable number of read ports.

Parameters:
ROW_SIZE, 1280, samples per row
WIN_SIZE, 128, samples per window word
BEAT_SIZE, 8, samples per input beat
DATA_WIDTH, 16, bits per sample
NUM_RD, 8, number of read ports (any value >=1)
READ_LATENCY, 2, cycles from rd_addr sample to rd_data (>=1)
Derived values:
- WIN_NUM=ROW_SIZE/WIN_SIZE
- ADDR_WIDTH=$clog2(WIN_NUM)
- WIN_BEATS=WIN_SIZE/BEAT_SIZE
- BEAT_NUM=ROW_SIZE/BEAT_SIZE
- BEAT_WIDTH=BEAT_SIZE*DATA_WIDTH
- CACHE_WIDTH=WIN_SIZE*DATA_WIDTH
- Legal configurations require both divisions to be exact and WIN_BEATS>=2.

Ports:
aclk  in  1  clock
areset  in  1  reset; one clock; reset is synchronous and active-high
s_axis_tdata  in  BEAT_WIDTH  input beat; sample j at bits [j*DATA_WIDTH+:DATA_WIDTH]
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accepted when tvalid&tready
s_axis_tlast  in  1  last beat of row
rd_valid  out  1  read bank holds a complete row
rd_bank  out  1  index of bank currently presented for reading
rd_release  in  1  single-cycle pulse; frees the read bank
rd_addr  in  NUM_RD*ADDR_WIDTH  window index per port
rd_data  out  NUM_RD*CACHE_WIDTH  window word per port
err_len  out  1  sticky row-length error
rows_done  out  16  completed-row count; wraps at 2^16

Behaviour:
- State per bank: full flag. Pointers wr_bank and rd_bank both reset to 0. Write side has two states:
  - FILL: full[wr_bank]=0.
  - WAIT: full[wr_bank]=1.
  - s_axis_tready = !areset & !full[wr_bank], registered so it is valid the cycle after any state change.
- Packing:
  - Beat counter b runs 0..BEAT_NUM-1.
  - Beat b lands in lane b%WIN_BEATS, at bits [(b%WIN_BEATS)*BEAT_WIDTH+:BEAT_WIDTH] of window b/WIN_BEATS.
  - On the handshake of lane WIN_BEATS-1, the full word (accumulated lanes plus the incoming beat) is written to bank[wr_bank] at that edge.
- Row end:
  - Triggered by the handshake of beat BEAT_NUM-1, or by an early tlast.
  - At that edge: full[wr_bank]<=1, wr_bank toggles, b<=0, rows_done increments.
- Length errors:
  - Early tlast (b<BEAT_NUM-1): the partial window is committed with unfilled lanes zero. Windows never written keep stale contents. err_len<=1.
  - Missing tlast on beat BEAT_NUM-1: the row still completes; err_len<=1.
  - err_len clears only on reset.
- rd_valid is registered from full[rd_bank]. It rises on the cycle after the row-end handshake edge when that row is in rd_bank.
- rd_release:
  - Honoured only when rd_valid=1; ignored otherwise.
  - At that edge: full[rd_bank]<=0, rd_bank toggles, rd_valid<=0 for exactly one cycle, then follows full of the new rd_bank.
  - If the writer was in WAIT on the released bank, tready rises on the following cycle.
- Simultaneous release and row-end on the other bank: both take effect. rd_valid is 0 for one cycle, then 1.
- Read ports:
  - Fully pipelined; each port samples rd_addr every cycle from bank[rd_bank as of the sample cycle].
  - rd_data is presented exactly READ_LATENCY cycles later.
  - Address >= WIN_NUM returns 0.
  - Data is defined only if rd_valid=1 in the sample cycle.
  - A release mid-pipeline does not corrupt in-flight reads.
- Reset: tready=0, rd_valid=0, rd_bank=0, err_len=0, rows_done=0, rd_data=0, full flags cleared, partial row discarded. Storage contents are not cleared.

Test Plan:
1. Defaults, one 160-beat row, beat k samples = k*8+j, rd_addr all ports = 0..9 sweep -> rd_valid at cycle after beat 159. Port p window w, sample s = w*128+s, 2 cycles after address; rows_done=1.
2. Three back-to-back rows, no release -> tready drops after row 2 completes; row 3 stalls. rd_release -> rd_bank=1, rd_valid low 1 cycle then high; tready high next cycle, row 3 loads into bank 0.
3. tlast on beat 20 -> err_len=1; window 1 lanes 5..15 read 0; rd_valid=1; next beat starts window 0 of a new row.
4. No tlast on beat 159, then a normal row -> err_len=1, both rows stored intact, rows_done=2.
5. rd_release same cycle as final beat of the row in the other bank -> rd_valid 1,0,1 sequence; data from new bank correct; release pulses while rd_valid=0 have no effect.
6. areset asserted at beat 80 of a row -> all outputs at reset values next cycle; new full row after reset reads correctly from bank 0.

Source files
------------

// File: rtl/phase_cache_pp.sv
// Ping-pong phase cache. Packs one AXI-stream row of phase samples into
// WIN_SIZE-sample window words in one of two banks. NUM_RD pipelined read ports
// are served from the completed bank while the other bank loads.
module phase_cache_pp #(
  parameter int ROW_SIZE     = 1280,
  parameter int WIN_SIZE     = 128,
  parameter int BEAT_SIZE    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_RD       = 8,
  parameter int READ_LATENCY = 2,
  localparam int WIN_NUM     = ROW_SIZE / WIN_SIZE,
  localparam int ADDR_WIDTH  = (WIN_NUM > 1) ? $clog2(WIN_NUM) : 1,
  localparam int WIN_BEATS   = WIN_SIZE / BEAT_SIZE,
  localparam int BEAT_WIDTH  = BEAT_SIZE * DATA_WIDTH,
  localparam int CACHE_WIDTH = WIN_SIZE * DATA_WIDTH
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [BEAT_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic                          rd_valid,
  output logic                          rd_bank,
  input  logic                          rd_release,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_RD*CACHE_WIDTH-1:0] rd_data,
  output logic                          err_len,
  output logic [15:0]                   rows_done
);

  localparam int LANE_W = $clog2(WIN_BEATS);

  // Write-side position inside the row: lane within window, window within row.
  logic [LANE_W-1:0]     r_lane;
  logic [ADDR_WIDTH-1:0] r_win;
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_tready;
  logic                  r_rd_valid;
  logic                  r_err_len;
  logic [15:0]           r_rows_done;

  // Lanes 0..WIN_BEATS-2 of the window being assembled; the last lane is
  // taken straight from the bus when the word is committed.
  logic [(WIN_BEATS-1)*BEAT_WIDTH-1:0] r_acc;
  logic [CACHE_WIDTH-1:0]              r_mem [2][WIN_NUM];

  logic                   w_hs;
  logic                   w_last_beat;
  logic                   w_row_end;
  logic                   w_commit;
  logic                   w_rel;
  logic [1:0]             w_full_nxt;
  logic                   w_wr_bank_nxt;
  logic [CACHE_WIDTH-1:0] w_word;

  // areset gates the handshake so a beat offered during reset is dropped.
  assign w_hs          = s_axis_tvalid & r_tready & ~areset;
  assign w_last_beat   = (r_win == ADDR_WIDTH'(WIN_NUM-1)) && (r_lane == LANE_W'(WIN_BEATS-1));
  assign w_row_end     = w_hs & (w_last_beat | s_axis_tlast);
  assign w_commit      = w_hs & ((r_lane == LANE_W'(WIN_BEATS-1)) | w_row_end);
  assign w_rel         = rd_release & r_rd_valid;
  assign w_wr_bank_nxt = r_wr_bank ^ w_row_end;

  // A row end never targets the bank being released: the writer stalls on a full bank.
  assign w_full_nxt[0] = (r_full[0] & ~(w_rel & ~r_rd_bank)) | (w_row_end & ~r_wr_bank);
  assign w_full_nxt[1] = (r_full[1] & ~(w_rel &  r_rd_bank)) | (w_row_end &  r_wr_bank);

  // Committed word: earlier lanes from the accumulator, current lane from the bus, later lanes zero.
  always_comb begin
    w_word = '0;
    for (int l = 0; l < WIN_BEATS-1; l++) begin
      w_word[l*BEAT_WIDTH +: BEAT_WIDTH] = (r_lane == LANE_W'(l)) ? s_axis_tdata :
                                           (LANE_W'(l) < r_lane) ? r_acc[l*BEAT_WIDTH +: BEAT_WIDTH] :
                                           {BEAT_WIDTH{1'b0}};
    end
    w_word[(WIN_BEATS-1)*BEAT_WIDTH +: BEAT_WIDTH] =
      (r_lane == LANE_W'(WIN_BEATS-1)) ? s_axis_tdata : {BEAT_WIDTH{1'b0}};
  end

  // Bank storage and lane accumulator; contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_commit) begin
      r_mem[r_wr_bank][r_win] <= w_word;
    end
    for (int l = 0; l < WIN_BEATS-1; l++) begin
      if (w_hs && (r_lane == LANE_W'(l))) begin
        r_acc[l*BEAT_WIDTH +: BEAT_WIDTH] <= s_axis_tdata;
      end
    end
  end

  // Bank hand-off, flow control, row counting and length-error tracking.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_lane      <= '0;
      r_win       <= '0;
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_tready    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_err_len   <= 1'b0;
      r_rows_done <= 16'd0;
    end else begin
      r_full     <= w_full_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= r_rd_bank ^ w_rel;
      r_tready   <= ~w_full_nxt[w_wr_bank_nxt];
      // After a release the old bank's flag is gone; hold low one cycle, then track the new bank.
      r_rd_valid <= ~w_rel & w_full_nxt[r_rd_bank];
      if (w_row_end) begin
        r_rows_done <= r_rows_done + 16'd1;
      end
      if (w_hs && (s_axis_tlast != w_last_beat)) begin
        r_err_len <= 1'b1;
      end
      if (w_row_end) begin
        r_lane <= '0;
        r_win  <= '0;
      end else if (w_hs && (r_lane == LANE_W'(WIN_BEATS-1))) begin
        r_lane <= '0;
        r_win  <= r_win + ADDR_WIDTH'(1);
      end else if (w_hs) begin
        r_lane <= r_lane + LANE_W'(1);
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign rd_valid      = r_rd_valid;
  assign rd_bank       = r_rd_bank;
  assign err_len       = r_err_len;
  assign rows_done     = r_rows_done;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [CACHE_WIDTH-1:0] w_rdw;
    logic [CACHE_WIDTH-1:0] r_pipe [READ_LATENCY];

    assign w_addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_rdw  = ({1'b0, w_addr} < (ADDR_WIDTH+1)'(WIN_NUM)) ? r_mem[r_rd_bank][w_addr] : '0;

    // Read pipeline: bank chosen at the sample edge, so a later release cannot disturb in-flight data.
    always_ff @(posedge aclk) begin
      if (areset) begin
        for (int s = 0; s < READ_LATENCY; s++) begin
          r_pipe[s] <= '0;
        end
      end else begin
        r_pipe[0] <= w_rdw;
        for (int s = 1; s < READ_LATENCY; s++) begin
          r_pipe[s] <= r_pipe[s-1];
        end
      end
    end

    assign rd_data[p*CACHE_WIDTH +: CACHE_WIDTH] = r_pipe[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_phase_cache_pp.sv
// Scoreboard bench for phase_cache_pp: the stimulus thread pushes expected read
// words, a monitor pops and compares when each read emerges from the pipeline.
module tb_phase_cache_pp;

  localparam int ROW_SIZE  = 1280;
  localparam int WIN_SIZE  = 128;
  localparam int BEAT_SIZE = 8;
  localparam int DW        = 16;
  localparam int NUM_RD    = 8;
  localparam int LAT       = 2;
  localparam int WIN_NUM   = ROW_SIZE / WIN_SIZE;
  localparam int AW        = $clog2(WIN_NUM);
  localparam int WB        = WIN_SIZE / BEAT_SIZE;
  localparam int BEAT_NUM  = ROW_SIZE / BEAT_SIZE;
  localparam int BW        = BEAT_SIZE * DW;
  localparam int CW        = WIN_SIZE * DW;

  logic                   clk = 1'b0;
  logic                   areset;
  logic [BW-1:0]          tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic                   rd_valid;
  logic                   rd_bank;
  logic                   rd_release;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*CW-1:0]   rd_data;
  logic                   err_len;
  logic [15:0]            rows_done;

  phase_cache_pp #(
    .ROW_SIZE(ROW_SIZE), .WIN_SIZE(WIN_SIZE), .BEAT_SIZE(BEAT_SIZE),
    .DATA_WIDTH(DW), .NUM_RD(NUM_RD), .READ_LATENCY(LAT)
  ) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_release(rd_release),
    .rd_addr(rd_addr), .rd_data(rd_data), .err_len(err_len), .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0]        mdl [2][WIN_NUM];
  logic [CW-1:0]        tb_word;
  logic [NUM_RD*CW-1:0] sb_q [$];
  logic [NUM_RD*CW-1:0] mon_exp;
  int                   mon_fs;
  logic                 rd_issue = 1'b0;
  logic [LAT-1:0]       pend = '0;
  int                   eb;
  int                   wb;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Tracks which cycles carry a read result.
  always @(posedge clk) pend <= {pend[LAT-2:0], rd_issue};

  // Monitor: compare every emerging read against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (pend[LAT-1]) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_data: read result with empty scoreboard (t=%0t)", $time);
      end else begin
        mon_exp = sb_q.pop_front();
        for (int p = 0; p < NUM_RD; p++) begin
          n_checks++;
          if (rd_data[p*CW +: CW] !== mon_exp[p*CW +: CW]) begin
            n_errors++;
            mon_fs = 0;
            for (int s = WIN_SIZE-1; s >= 0; s--)
              if (rd_data[p*CW + s*DW +: DW] !== mon_exp[p*CW + s*DW +: DW]) mon_fs = s;
            $display("FAIL rd_data port %0d sample %0d: got %h expected %h (t=%0t)", p, mon_fs,
                     rd_data[p*CW + mon_fs*DW +: DW], mon_exp[p*CW + mon_fs*DW +: DW], $time);
          end
        end
      end
    end
  end

  function automatic logic [BW-1:0] mk_beat(input int base, input int k);
    logic [BW-1:0] b;
    for (int j = 0; j < BEAT_SIZE; j++) b[j*DW +: DW] = DW'(base + k*BEAT_SIZE + j);
    return b;
  endfunction

  // Offer one beat (called at posedge+1); returns at posedge+1 after the handshake edge.
  task automatic send_beat(input logic [BW-1:0] d, input bit last, input bit rel);
    int t;
    bit acc;
    tdata = d; tlast = last; tvalid = 1'b1; rd_release = rel; t = 0;
    do begin
      acc = tready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 4000);
    tvalid = 1'b0; tlast = 1'b0; rd_release = 1'b0;
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_beat: tready never rose within %0d cycles", t);
    end
  endtask

  // Send beats k0..k1-1 of a row; tl is the beat carrying tlast (-1 for none).
  // rel asserts rd_release together with the final beat sent.
  task automatic send_beats(input int base, input int k0, input int k1, input int tl, input bit rel);
    logic [BW-1:0] b;
    int lane, w;
    bit end_row, r;
    for (int k = k0; k < k1; k++) begin
      b = mk_beat(base, k);
      lane = k % WB;
      w = k / WB;
      r = rel && (k == k1-1);
      send_beat(b, k == tl, r);
      if (r) eb ^= 1;
      tb_word[lane*BW +: BW] = b;
      end_row = (k == tl) || (k == BEAT_NUM-1);
      if (lane == WB-1 || end_row) begin
        mdl[wb][w] = tb_word;
        tb_word = '0;
      end
      if (end_row) wb ^= 1;
    end
  endtask

  // Port p reads window (a+p) mod 2^AW; rel also pulses rd_release (expected honoured).
  task automatic read_cycle(input int a, input bit rel);
    logic [NUM_RD*CW-1:0] e;
    int ad;
    for (int p = 0; p < NUM_RD; p++) begin
      ad = (a + p) % (1 << AW);
      rd_addr[p*AW +: AW] = AW'(ad);
      e[p*CW +: CW] = (ad < WIN_NUM) ? mdl[eb][ad] : '0;
    end
    sb_q.push_back(e);
    rd_issue = 1'b1; rd_release = rel;
    @(posedge clk); #1;
    rd_issue = 1'b0; rd_release = 1'b0;
    if (rel) eb ^= 1;
  endtask

  task automatic pulse_release(input bit taken);
    rd_release = 1'b1;
    @(posedge clk); #1;
    rd_release = 1'b0;
    if (taken) eb ^= 1;
  endtask

  initial begin
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; rd_release = 1'b0; rd_addr = '0;
    eb = 0; wb = 0; tb_word = '0;
    for (int b = 0; b < 2; b++) for (int w = 0; w < WIN_NUM; w++) mdl[b][w] = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset_tready", 32'(tready), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_bank", 32'(rd_bank), 32'd0);
    chk("reset_err_len", 32'(err_len), 32'd0);
    chk("reset_rows_done", 32'(rows_done), 32'd0);
    chk("reset_rd_data_zero", 32'(rd_data == '0), 32'd1);
    areset = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_reset", 32'(tready), 32'd1);
    pulse_release(1'b0);
    chk("idle_release_bank", 32'(rd_bank), 32'd0);
    chk("idle_release_valid", 32'(rd_valid), 32'd0);

    // Test 1: one full row, sweep all windows.
    send_beats(0, 0, BEAT_NUM-1, BEAT_NUM-1, 1'b0);
    chk("t1_valid_before_last", 32'(rd_valid), 32'd0);
    send_beats(0, BEAT_NUM-1, BEAT_NUM, BEAT_NUM-1, 1'b0);
    chk("t1_valid_after_last", 32'(rd_valid), 32'd1);
    chk("t1_rd_bank", 32'(rd_bank), 32'd0);
    chk("t1_rows_done", 32'(rows_done), 32'd1);
    chk("t1_tready", 32'(tready), 32'd1);
    chk("t1_err_len", 32'(err_len), 32'd0);
    for (int a = 0; a < WIN_NUM; a++) read_cycle(a, 1'b0);

    // Test 2: second row fills bank 1, third row stalls until release.
    send_beats(1000, 0, BEAT_NUM, BEAT_NUM-1, 1'b0);
    chk("t2_tready_low", 32'(tready), 32'd0);
    chk("t2_rows_done", 32'(rows_done), 32'd2);
    tdata = mk_beat(2000, 0); tvalid = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t2_stall_tready", 32'(tready), 32'd0);
    chk("t2_stall_rows", 32'(rows_done), 32'd2);
    tvalid = 1'b0;
    read_cycle(3, 1'b1);
    chk("t2_rel_bank", 32'(rd_bank), 32'd1);
    chk("t2_rel_valid_low", 32'(rd_valid), 32'd0);
    chk("t2_rel_tready", 32'(tready), 32'd1);
    @(posedge clk); #1;
    chk("t2_rel_valid_high", 32'(rd_valid), 32'd1);
    send_beats(2000, 0, BEAT_NUM, BEAT_NUM-1, 1'b0);
    chk("t2_row3_rows", 32'(rows_done), 32'd3);
    chk("t2_row3_tready", 32'(tready), 32'd0);
    read_cycle(0, 1'b0); read_cycle(5, 1'b0); read_cycle(9, 1'b0);
    pulse_release(1'b1);
    chk("t2_rel2_bank", 32'(rd_bank), eb);
    @(posedge clk); #1;
    read_cycle(0, 1'b0); read_cycle(9, 1'b0);

    // Test 4: missing tlast, then a normal row; both intact.
    send_beats(4000, 0, BEAT_NUM, -1, 1'b0);
    chk("t4_err_len", 32'(err_len), 32'd1);
    chk("t4_rows", 32'(rows_done), 32'd4);
    pulse_release(1'b1);
    @(posedge clk); #1;
    read_cycle(0, 1'b0); read_cycle(9, 1'b0);
    send_beats(5000, 0, BEAT_NUM, BEAT_NUM-1, 1'b0);
    chk("t4_rows2", 32'(rows_done), 32'd5);
    pulse_release(1'b1);
    @(posedge clk); #1;
    chk("t4_bank", 32'(rd_bank), 32'd0);
    read_cycle(0, 1'b0); read_cycle(4, 1'b0); read_cycle(9, 1'b0);

    // Test 5: release on the same edge as the final beat of the other bank.
    send_beats(6000, 0, BEAT_NUM-1, BEAT_NUM-1, 1'b0);
    chk("t5_valid_pre", 32'(rd_valid), 32'd1);
    send_beats(6000, BEAT_NUM-1, BEAT_NUM, BEAT_NUM-1, 1'b1);
    chk("t5_valid_gap", 32'(rd_valid), 32'd0);
    chk("t5_bank", 32'(rd_bank), 32'd1);
    chk("t5_rows", 32'(rows_done), 32'd6);
    pulse_release(1'b0);
    chk("t5_valid_back", 32'(rd_valid), 32'd1);
    chk("t5_bank_kept", 32'(rd_bank), 32'd1);
    chk("t5_tready", 32'(tready), 32'd1);
    read_cycle(0, 1'b0); read_cycle(7, 1'b0); read_cycle(9, 1'b0);

    // Test 6: reset in the middle of a row.
    send_beats(7000, 0, 80, -1, 1'b0);
    tdata = mk_beat(7000, 80); tvalid = 1'b1; areset = 1'b1;
    @(posedge clk); #1;
    chk("t6_tready", 32'(tready), 32'd0);
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rd_bank", 32'(rd_bank), 32'd0);
    chk("t6_err_len", 32'(err_len), 32'd0);
    chk("t6_rows", 32'(rows_done), 32'd0);
    chk("t6_rd_data_zero", 32'(rd_data == '0), 32'd1);
    tvalid = 1'b0;
    @(posedge clk); #1;
    areset = 1'b0; eb = 0; wb = 0; tb_word = '0;
    @(posedge clk); #1;
    chk("t6_tready_back", 32'(tready), 32'd1);
    send_beats(8000, 0, BEAT_NUM, BEAT_NUM-1, 1'b0);
    chk("t6_valid", 32'(rd_valid), 32'd1);
    chk("t6_bank0", 32'(rd_bank), 32'd0);
    chk("t6_rows1", 32'(rows_done), 32'd1);
    for (int a = 0; a < WIN_NUM; a++) read_cycle(a, 1'b0);

    // Test 3: early tlast on beat 20; partial window zero-filled, later windows stale.
    send_beats(9000, 0, 21, 20, 1'b0);
    chk("t3_err_len", 32'(err_len), 32'd1);
    chk("t3_rows", 32'(rows_done), 32'd2);
    chk("t3_tready", 32'(tready), 32'd0);
    pulse_release(1'b1);
    @(posedge clk); #1;
    chk("t3_valid", 32'(rd_valid), 32'd1);
    chk("t3_bank", 32'(rd_bank), 32'd1);
    read_cycle(0, 1'b0); read_cycle(1, 1'b0); read_cycle(2, 1'b0); read_cycle(9, 1'b0);
    send_beats(10000, 0, BEAT_NUM, BEAT_NUM-1, 1'b0);
    chk("t3_rows_next", 32'(rows_done), 32'd3);
    pulse_release(1'b1);
    @(posedge clk); #1;
    read_cycle(0, 1'b0); read_cycle(9, 1'b0);

    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
